// File: rtl/pb_strobe_ctrl.sv
// Port B strobed-input handshake controller (8255-style mode 1 input).
// The external strobe and the decoded CPU read are synchronised into the clk
// domain. A four-state handshake then drives the input latch enable, IBF and
// INTR, and counts strobes that arrive while the buffer still holds data.
module pb_strobe_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic       mode1,
   input  logic       mode_wr,
   input  logic       stb_n,
   input  logic       rd_n,
   input  logic       pb_sel,
   input  logic       inte_wr,
   input  logic       inte_val,
   output logic       PBInLd,
   output logic       ibf,
   output logic       intr,
   output logic       inte,
   output logic [3:0] ovr_cnt
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] STROBE  = 2'd1;
   localparam logic [1:0] FULL    = 2'd2;
   localparam logic [1:0] READING = 2'd3;

   logic       stb_s1, stb_s2, stb_h;
   logic       rd_s1, rd_s2, rd_h;
   logic       rd_pin;
   logic       stb_fall, stb_rise, rd_fall, rd_rise;

   logic [1:0] state, state_nx;
   logic       ibf_nx;
   logic       req, req_nx;
   logic       ld_nx;
   logic       ovr_inc;

   // A read only counts as a port B read when the address decodes port B.
   assign rd_pin = rd_n | ~pb_sel;

   // Two-flop synchronisers plus one history flop per input for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stb_s1 <= 1'b1;
         stb_s2 <= 1'b1;
         stb_h  <= 1'b1;
         rd_s1  <= 1'b1;
         rd_s2  <= 1'b1;
         rd_h   <= 1'b1;
      end else begin
         stb_s1 <= stb_n;
         stb_s2 <= stb_s1;
         stb_h  <= stb_s2;
         rd_s1  <= rd_pin;
         rd_s2  <= rd_s1;
         rd_h   <= rd_s2;
      end
   end

   assign stb_fall = ~stb_s2 &  stb_h;
   assign stb_rise =  stb_s2 & ~stb_h;
   assign rd_fall  = ~rd_s2  &  rd_h;
   assign rd_rise  =  rd_s2  & ~rd_h;

   // Handshake next-state logic. A control-word write overrides everything,
   // and mode 0 parks the machine in IDLE with the latch left transparent.
   always_comb begin
      state_nx = state;
      ibf_nx   = ibf;
      req_nx   = req;
      ovr_inc  = 1'b0;
      if (!mode1) begin
         state_nx = IDLE;
         ibf_nx   = 1'b0;
         req_nx   = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (stb_fall) begin
                  state_nx = STROBE;
                  ibf_nx   = 1'b1;
               end
            end
            STROBE: begin
               if (stb_rise) begin
                  state_nx = FULL;
                  req_nx   = 1'b1;
               end
            end
            FULL: begin
               ovr_inc = stb_fall;
               if (rd_fall) begin
                  state_nx = READING;
                  req_nx   = 1'b0;
               end
            end
            READING: begin
               if (rd_rise) begin
                  if (stb_fall) begin
                     state_nx = STROBE;
                  end else begin
                     state_nx = IDLE;
                     ibf_nx   = 1'b0;
                  end
               end else begin
                  ovr_inc = stb_fall;
               end
            end
            default: begin
               state_nx = IDLE;
               ibf_nx   = 1'b0;
               req_nx   = 1'b0;
            end
         endcase
      end
      if (mode_wr) begin
         state_nx = IDLE;
         ibf_nx   = 1'b0;
         req_nx   = 1'b0;
         ovr_inc  = 1'b0;
      end
      ld_nx = mode1 ? (state_nx != STROBE) : 1'b0;
   end

   // Register the handshake state and every output-facing flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         ibf    <= 1'b0;
         req    <= 1'b0;
         PBInLd <= 1'b1;
      end else begin
         state  <= state_nx;
         ibf    <= ibf_nx;
         req    <= req_nx;
         PBInLd <= ld_nx;
      end
   end

   // INTE B flag: bit set/reset writes, cleared by any control-word write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inte <= 1'b0;
      end else if (mode_wr) begin
         inte <= 1'b0;
      end else if (inte_wr) begin
         inte <= inte_val;
      end
   end

   // Saturating count of strobes that arrived while the buffer was occupied.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovr_cnt <= 4'd0;
      end else if (mode_wr) begin
         ovr_cnt <= 4'd0;
      end else if (ovr_inc && (ovr_cnt != 4'd15)) begin
         ovr_cnt <= ovr_cnt + 4'd1;
      end
   end

   // The request stays pending internally; INTE only gates what the CPU sees.
   assign intr = req & inte;

endmodule

// File: tb/tb_pb_strobe_ctrl.sv
// Self-checking bench for pb_strobe_ctrl: directed handshake scenarios
// followed by randomised pin activity, compared against a transaction-level
// model of the buffer that sees each pin through a two-edge delay line.
module tb_pb_strobe_ctrl;

   logic       clk;
   logic       reset;
   logic       mode1, mode_wr, stb_n, rd_n, pb_sel, inte_wr, inte_val;
   logic       PBInLd, ibf, intr, inte;
   logic [3:0] ovr_cnt;

   int    checks = 0;
   int    errors = 0;
   string phase  = "init";

   // Model: pin history delay lines and buffer occupancy flags
   bit stbQ[$];
   bit rdQ[$];
   bit ibfM, latchOpen, cpuReading, reqM, inteM, ldM;
   int ovrM;

   pb_strobe_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .mode1    (mode1),
      .mode_wr  (mode_wr),
      .stb_n    (stb_n),
      .rd_n     (rd_n),
      .pb_sel   (pb_sel),
      .inte_wr  (inte_wr),
      .inte_val (inte_val),
      .PBInLd   (PBInLd),
      .ibf      (ibf),
      .intr     (intr),
      .inte     (inte),
      .ovr_cnt  (ovr_cnt)
   );

   // Free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void modelReset();
      stbQ       = {1'b1, 1'b1, 1'b1};
      rdQ        = {1'b1, 1'b1, 1'b1};
      ibfM       = 1'b0;
      latchOpen  = 1'b0;
      cpuReading = 1'b0;
      reqM       = 1'b0;
      inteM      = 1'b0;
      ldM        = 1'b1;
      ovrM       = 0;
   endfunction

   // One clock edge of the reference model. A pin level sampled at edge n
   // becomes visible as an edge event at edge n+2.
   function automatic void modelEdge();
      bit stbFall, stbRise, rdFall, rdRise;
      if (reset) begin
         modelReset();
         return;
      end
      stbFall = (stbQ[1] == 1'b0) && (stbQ[2] == 1'b1);
      stbRise = (stbQ[1] == 1'b1) && (stbQ[2] == 1'b0);
      rdFall  = (rdQ[1] == 1'b0) && (rdQ[2] == 1'b1);
      rdRise  = (rdQ[1] == 1'b1) && (rdQ[2] == 1'b0);
      stbQ.push_front(stb_n);
      void'(stbQ.pop_back());
      rdQ.push_front(rd_n | ~pb_sel);
      void'(rdQ.pop_back());

      if (mode_wr) begin
         ibfM = 0; latchOpen = 0; cpuReading = 0; reqM = 0; inteM = 0; ovrM = 0;
         ldM  = mode1;
         return;
      end
      if (inte_wr) inteM = inte_val;
      if (!mode1) begin
         ibfM = 0; latchOpen = 0; cpuReading = 0; reqM = 0;
      end else if (!ibfM) begin
         if (stbFall) begin ibfM = 1; latchOpen = 1; end
      end else if (latchOpen) begin
         if (stbRise) begin latchOpen = 0; reqM = 1; end
      end else if (!cpuReading) begin
         if (stbFall && ovrM < 15) ovrM++;
         if (rdFall) begin cpuReading = 1; reqM = 0; end
      end else begin
         if (rdRise && stbFall) begin cpuReading = 0; latchOpen = 1; end
         else if (rdRise) begin cpuReading = 0; ibfM = 0; end
         else if (stbFall && ovrM < 15) ovrM++;
      end
      ldM = mode1 ? !latchOpen : 1'b0;
   endfunction

   task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, "_ld"},   {3'b000, PBInLd}, {3'b000, ldM});
      checkOutput({tag, "_ibf"},  {3'b000, ibf},    {3'b000, ibfM});
      checkOutput({tag, "_intr"}, {3'b000, intr},   {3'b000, reqM & inteM});
      checkOutput({tag, "_inte"}, {3'b000, inte},   {3'b000, inteM});
      checkOutput({tag, "_ovr"},  ovr_cnt,          4'(ovrM));
   endtask

   // Advance n clocks with the current inputs, checking every cycle on negedge
   task automatic applyStimulus(input int n);
      repeat (n) begin
         @(posedge clk);
         modelEdge();
         @(negedge clk);
         checkAll(phase);
      end
   endtask

   // Asynchronous reset pulse raised between edges, checked before any edge
   task automatic pulseReset();
      reset = 1'b1;
      #1;
      modelReset();
      checkAll({phase, "_rst_async"});
      checkOutput({phase, "_rst_ld"}, {3'b000, PBInLd}, 4'd1);
      applyStimulus(1);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; mode1 = 1'b0; mode_wr = 1'b0; stb_n = 1'b1; rd_n = 1'b1;
      pb_sel = 1'b0; inte_wr = 1'b0; inte_val = 1'b0;
      modelReset();
      #2;
      phase = "reset";
      checkAll(phase);
      applyStimulus(2);
      reset = 1'b0;

      // Mode 0: latch transparent, strobes ignored
      phase = "mode0";
      for (int i = 0; i < 10; i++) begin
         stb_n = ~stb_n;
         applyStimulus(1);
         checkOutput("mode0_ld_const", {3'b000, PBInLd}, 4'd0);
      end
      stb_n = 1'b1;

      // Enter mode 1 with INTE set, full strobe/read handshake
      phase = "m1_inte1";
      mode1 = 1'b1; mode_wr = 1'b1;
      applyStimulus(1);
      mode_wr = 1'b0; inte_wr = 1'b1; inte_val = 1'b1;
      applyStimulus(1);
      inte_wr = 1'b0;
      applyStimulus(3);
      stb_n = 1'b0;
      applyStimulus(2);
      checkOutput("lat_before_ibf", {3'b000, ibf}, 4'd0);
      applyStimulus(1);
      checkOutput("lat_k2_ibf", {3'b000, ibf}, 4'd1);
      checkOutput("lat_k2_ld", {3'b000, PBInLd}, 4'd0);
      applyStimulus(2);
      stb_n = 1'b1;
      applyStimulus(2);
      checkOutput("intr_before", {3'b000, intr}, 4'd0);
      applyStimulus(1);
      checkOutput("intr_after_rise", {3'b000, intr}, 4'd1);
      applyStimulus(1);
      pb_sel = 1'b1; rd_n = 1'b0;
      applyStimulus(3);
      checkOutput("rd_clears_intr", {3'b000, intr}, 4'd0);
      checkOutput("rd_ibf_held", {3'b000, ibf}, 4'd1);
      rd_n = 1'b1;
      applyStimulus(3);
      checkOutput("rd_rise_ibf", {3'b000, ibf}, 4'd0);

      // INTE cleared: request stays hidden until INTE is set in FULL
      phase = "m1_inte0";
      inte_wr = 1'b1; inte_val = 1'b0;
      applyStimulus(1);
      inte_wr = 1'b0;
      stb_n = 1'b0;
      applyStimulus(3);
      stb_n = 1'b1;
      applyStimulus(4);
      checkOutput("inte0_intr", {3'b000, intr}, 4'd0);
      checkOutput("inte0_ibf", {3'b000, ibf}, 4'd1);
      inte_wr = 1'b1; inte_val = 1'b1;
      applyStimulus(1);
      inte_wr = 1'b0;
      checkOutput("inte_set_intr", {3'b000, intr}, 4'd1);

      // Read of another port while FULL changes nothing
      phase = "other_port";
      pb_sel = 1'b0; rd_n = 1'b0;
      applyStimulus(4);
      checkOutput("other_port_intr", {3'b000, intr}, 4'd1);
      rd_n = 1'b1; pb_sel = 1'b1;
      applyStimulus(1);

      // 17 overrun strobes in FULL saturate the counter
      phase = "overrun";
      for (int i = 0; i < 17; i++) begin
         stb_n = 1'b0;
         applyStimulus(2);
         stb_n = 1'b1;
         applyStimulus(2);
      end
      applyStimulus(2);
      checkOutput("ovr_sat", ovr_cnt, 4'd15);
      checkOutput("ovr_ibf", {3'b000, ibf}, 4'd1);
      checkOutput("ovr_ld", {3'b000, PBInLd}, 4'd1);

      // READING: rd rise and stb fall on the same edge go straight to STROBE
      phase = "rd_rise_stb_fall";
      rd_n = 1'b0;
      applyStimulus(3);
      rd_n = 1'b1; stb_n = 1'b0;
      applyStimulus(3);
      checkOutput("rdstb_ld", {3'b000, PBInLd}, 4'd0);
      checkOutput("rdstb_ibf", {3'b000, ibf}, 4'd1);
      checkOutput("rdstb_ovr", ovr_cnt, 4'd15);
      stb_n = 1'b1;
      applyStimulus(4);

      // Control-word write in FULL clears everything
      phase = "mode_wr_full";
      mode_wr = 1'b1;
      applyStimulus(1);
      mode_wr = 1'b0;
      checkOutput("mwr_ovr", ovr_cnt, 4'd0);
      checkOutput("mwr_inte", {3'b000, inte}, 4'd0);

      // FULL: rd fall and stb fall together -> read wins, strobe counted
      phase = "rd_fall_stb_fall";
      inte_wr = 1'b1; inte_val = 1'b1;
      applyStimulus(1);
      inte_wr = 1'b0; stb_n = 1'b0;
      applyStimulus(3);
      stb_n = 1'b1;
      applyStimulus(4);
      rd_n = 1'b0; stb_n = 1'b0;
      applyStimulus(3);
      checkOutput("rdwin_ovr", ovr_cnt, 4'd1);
      checkOutput("rdwin_intr", {3'b000, intr}, 4'd0);
      rd_n = 1'b1; stb_n = 1'b1;
      applyStimulus(4);
      checkOutput("rdwin_ibf", {3'b000, ibf}, 4'd0);

      // Reset in STROBE abandons the transfer
      phase = "rst_strobe";
      stb_n = 1'b0;
      applyStimulus(4);
      pulseReset();
      applyStimulus(3);
      stb_n = 1'b1;
      applyStimulus(4);

      // Randomised pin activity
      phase = "random";
      mode1 = 1'b1; mode_wr = 1'b1;
      applyStimulus(1);
      mode_wr = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 99) < 20) stb_n = ~stb_n;
         if ($urandom_range(0, 99) < 15) rd_n = ~rd_n;
         if ($urandom_range(0, 99) < 8) pb_sel = ~pb_sel;
         inte_wr  = ($urandom_range(0, 99) < 6);
         inte_val = 1'($urandom_range(0, 1));
         mode_wr  = ($urandom_range(0, 99) < 2);
         if (mode1) mode1 = ($urandom_range(0, 99) >= 2);
         else mode1 = ($urandom_range(0, 99) < 25);
         if ($urandom_range(0, 199) == 0) pulseReset();
         applyStimulus(1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
